timer_ctrl: RTL and testbench

Control sequencer for the digital timer's six-digit HH:MM:SS chain. Generates the 1 s tick and debounces the three front-panel buttons. Runs a run/pause/set state machine and drives per-digit advance strobes into the digit-iterator chain. Also produces the hour clear pulse for the 23→00 wrap, and the blink mask for the field being set.

---
 rtl/timer_ctrl.sv | 125 ++++++++++++
 tb/tb_timer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: 1 s prescaler, button debounce, run/pause/set FSM and digit strobes for the HH:MM:SS chain.
// Optional auto-repeat of a held inc button in set states: TIMER_CTRL_AUTO_REPEAT_EN.
module timer_ctrl #(
    parameter int CLK_DIV      = 1000,
    parameter int DEBOUNCE_CYC = 16,
    parameter int BLINK_DIV    = 500
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
   ,parameter int REPEAT_CYC   = 250
`endif
) (
    input  logic       timer_clk,
    input  logic       int_reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic [5:0] ovf_in,
    input  logic       hr_ones_at3,
    output logic [5:0] digit_adv,
    output logic       clr_hr,
    output logic       sec_tick,
    output logic [2:0] state_o,
    output logic [5:0] blink_mask,
    output logic       running
);
    localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, SET_HR = 3'd2, SET_MIN = 3'd3, SET_SEC = 3'd4;
    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);

    // button bit order in these vectors: 0=mode, 1=inc, 2=start
    logic [2:0] sync1, sync2, db, press;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0] state, state_n;
    logic [PW-1:0] pre;
    logic [BW-1:0] blk_cnt;
    logic phase, tick, in_set, in_set_n, set_entry, inc_any, wrap;
    logic a0, a1, a2, a3, a4, a5;

    always_ff @(posedge timer_clk or posedge int_reset)
        if (int_reset) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_start, btn_inc, btn_mode};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= (sync2[i] == db[i] || deb_cnt[i] == DEB_MAX) ? '0 : deb_cnt[i] + 1'b1;
                db[i]      <= (deb_cnt[i] == DEB_MAX && sync2[i] != db[i]) ? sync2[i] : db[i];
                press[i]   <= deb_cnt[i] == DEB_MAX && sync2[i] && !db[i];
            end
        end

`ifdef TIMER_CTRL_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] rep_cnt;
    logic rep_p;
    // any fresh press restarts the interval so repeats never crowd a real press
    always_ff @(posedge timer_clk or posedge int_reset)
        if (int_reset) begin
            rep_cnt <= '0;
            rep_p   <= 1'b0;
        end else begin
            rep_p   <= in_set && db[1] && !(|press) && rep_cnt == REP_MAX;
            rep_cnt <= (!in_set || !db[1] || |press || rep_cnt == REP_MAX) ? '0 : rep_cnt + 1'b1;
        end
    assign inc_any = press[1] | rep_p;
`else
    assign inc_any = press[1];
`endif

    assign in_set    = state == SET_HR || state == SET_MIN || state == SET_SEC;
    assign in_set_n  = state_n == SET_HR || state_n == SET_MIN || state_n == SET_SEC;
    assign set_entry = in_set_n && state_n != state;
    assign tick      = state == RUN && pre == PRE_MAX;

    assign state_n = (state > SET_SEC) ? IDLE :
                     press[2] ? (state == RUN ? IDLE : RUN) :
                     !press[0] ? state :
                     state == IDLE ? SET_HR :
                     state == RUN ? RUN :
                     state == SET_SEC ? IDLE : state + 3'd1;

    // carry chain; set-mode increments enter at their field and stop at its tens digit
    assign a0   = tick | (inc_any && state == SET_SEC);
    assign a1   = a0 & ovf_in[0];
    assign a2   = (tick & a1 & ovf_in[1]) | (inc_any && state == SET_MIN);
    assign a3   = a2 & ovf_in[2];
    assign a4   = (tick & a3 & ovf_in[3]) | (inc_any && state == SET_HR);
    assign a5   = a4 & ovf_in[4];
    assign wrap = a4 & ovf_in[5] & hr_ones_at3;

    always_ff @(posedge timer_clk or posedge int_reset)
        if (int_reset) begin
            state     <= IDLE;
            running   <= 1'b0;
            pre       <= '0;
            sec_tick  <= 1'b0;
            digit_adv <= '0;
            clr_hr    <= 1'b0;
            blk_cnt   <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_n;
            running   <= state_n == RUN;
            pre       <= tick ? '0 : state == RUN ? pre + 1'b1 : set_entry ? '0 : pre;
            sec_tick  <= tick;
            digit_adv <= {a5 & ~wrap, a4 & ~wrap, a3, a2, a1, a0};
            clr_hr    <= wrap;
            blk_cnt   <= (set_entry || blk_cnt == BLK_MAX) ? '0 : blk_cnt + 1'b1;
            phase     <= phase ^ (!set_entry && blk_cnt == BLK_MAX);
        end

    assign state_o    = state;
    assign blink_mask = !phase ? 6'b000000 :
                        state == SET_HR ? 6'b110000 :
                        state == SET_MIN ? 6'b001100 :
                        state == SET_SEC ? 6'b000011 : 6'b000000;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed vectors and hand-written sequences for timer_ctrl.
module tb_timer_ctrl;
    logic timer_clk = 1'b0, int_reset = 1'b1;
    logic btn_mode = 1'b0, btn_inc = 1'b0, btn_start = 1'b0, hr_ones_at3 = 1'b0;
    logic [5:0] ovf_in = '0;
    logic [5:0] digit_adv, blink_mask;
    logic clr_hr, sec_tick, running;
    logic [2:0] state_o;
    int total = 0, passed = 0, cyc = 0, strobes = 0;
    logic [5:0] last_adv = '0, mask_or = '0;
    logic last_clr = 1'b0;

`ifdef TIMER_CTRL_AUTO_REPEAT_EN
    localparam int EXP_REP = 4;
`else
    localparam int EXP_REP = 1;
`endif

    typedef struct {
        logic [5:0] ovf;
        logic       at3;
        logic [5:0] adv;
        logic       clr;
    } vec_t;
    vec_t vt[8];

    always #5 timer_clk = ~timer_clk;

    timer_ctrl #(
        .CLK_DIV(4), .DEBOUNCE_CYC(2), .BLINK_DIV(3)
`ifdef TIMER_CTRL_AUTO_REPEAT_EN
       ,.REPEAT_CYC(5)
`endif
    ) dut (
        .timer_clk(timer_clk), .int_reset(int_reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_start(btn_start), .ovf_in(ovf_in), .hr_ones_at3(hr_ones_at3), .digit_adv(digit_adv),
        .clr_hr(clr_hr), .sec_tick(sec_tick), .state_o(state_o), .blink_mask(blink_mask),
        .running(running)
    );

    always @(negedge timer_clk) begin
        if (digit_adv != 6'd0 || clr_hr) begin
            strobes++;
            last_adv = digit_adv;
            last_clr = clr_hr;
        end
        mask_or = mask_or | blink_mask;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge timer_clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == 0 || b == 3) btn_mode = v;
        if (b == 1) btn_inc = v;
        if (b == 2 || b == 3) btn_start = v;
    endtask

    // b: 0=mode 1=inc 2=start 3=start+mode
    task automatic push(input int b, input int hold);
        set_btn(b, 1'b1);
        step(hold);
        set_btn(b, 1'b0);
        step(10);
    endtask

    task automatic wait_tick(output int found);
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            step();
            if (sec_tick) found = 1;
        end
    endtask

    initial begin
        int found, t_prev, t_last;
        vt[0] = '{6'b000000, 1'b0, 6'b000001, 1'b0};
        vt[1] = '{6'b000001, 1'b0, 6'b000011, 1'b0};
        vt[2] = '{6'b000101, 1'b0, 6'b000011, 1'b0};
        vt[3] = '{6'b001111, 1'b0, 6'b011111, 1'b0};
        vt[4] = '{6'b011111, 1'b0, 6'b111111, 1'b0};
        vt[5] = '{6'b111111, 1'b1, 6'b001111, 1'b1};
        vt[6] = '{6'b111111, 1'b0, 6'b111111, 1'b0};
        vt[7] = '{6'b110000, 1'b1, 6'b000001, 1'b0};
        t_prev = 0;
        t_last = 0;

        step(3);
        check("reset state", int'(state_o), 0);
        check("reset outputs", int'({digit_adv, clr_hr, sec_tick, blink_mask, running}), 0);
        int_reset = 1'b0;
        step(2);

        btn_start = 1'b1;
        step(3);
        check("start min latency", int'(state_o), 0);
        for (int k = 0; k < 6 && state_o != 3'd1; k++) step();
        check("start to RUN", int'(state_o), 1);
        check("running in RUN", int'(running), 1);
        step(1);
        btn_start = 1'b0;

        for (int v = 0; v < 8; v++) begin
            ovf_in = vt[v].ovf;
            hr_ones_at3 = vt[v].at3;
            wait_tick(found);
            check($sformatf("tick%0d seen", v), found, 1);
            check($sformatf("tick%0d adv", v), int'(digit_adv), int'(vt[v].adv));
            check($sformatf("tick%0d clr", v), int'(clr_hr), int'(vt[v].clr));
            t_prev = t_last;
            t_last = cyc;
        end
        check("tick period", t_last - t_prev, 4);
        ovf_in = '0;
        hr_ones_at3 = 1'b0;

        push(2, 4);
        check("pause to IDLE", int'(state_o), 0);
        check("running off", int'(running), 0);
        strobes = 0;
        step(12);
        check("no tick in IDLE", strobes, 0);

        push(0, 4);
        check("mode to SET_HR", int'(state_o), 2);
        mask_or = '0;
        step(8);
        check("blink SET_HR", int'(mask_or), 6'b110000);
        ovf_in = 6'b010000;
        strobes = 0;
        push(1, 4);
        check("inc hr count", strobes, 1);
        check("inc hr adv", int'(last_adv), 6'b110000);
        check("inc hr clr", int'(last_clr), 0);
        ovf_in = 6'b110000;
        hr_ones_at3 = 1'b1;
        strobes = 0;
        push(1, 4);
        check("hr wrap count", strobes, 1);
        check("hr wrap adv", int'(last_adv), 0);
        check("hr wrap clr", int'(last_clr), 1);

        push(0, 4);
        check("mode to SET_MIN", int'(state_o), 3);
        mask_or = '0;
        step(8);
        check("blink SET_MIN", int'(mask_or), 6'b001100);
        ovf_in = 6'b001111;
        hr_ones_at3 = 1'b0;
        strobes = 0;
        push(1, 4);
        check("inc min adv", int'(last_adv), 6'b001100);

        push(0, 4);
        check("mode to SET_SEC", int'(state_o), 4);
        mask_or = '0;
        step(8);
        check("blink SET_SEC", int'(mask_or), 6'b000011);
        ovf_in = 6'b111111;
        hr_ones_at3 = 1'b1;
        strobes = 0;
        push(1, 4);
        check("inc sec adv", int'(last_adv), 6'b000011);
        check("inc sec clr", int'(last_clr), 0);

        ovf_in = '0;
        hr_ones_at3 = 1'b0;
        strobes = 0;
        btn_inc = 1'b1;
        step(20);
        btn_inc = 1'b0;
        step(15);
        check("held inc strobes", strobes, EXP_REP);
        check("held inc adv", int'(last_adv), 6'b000001);

        push(0, 4);
        check("mode to IDLE", int'(state_o), 0);
        mask_or = '0;
        step(8);
        check("no blink IDLE", int'(mask_or), 0);
        strobes = 0;
        push(1, 4);
        check("inc in IDLE", strobes, 0);

        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
        step(10);
        check("glitch ignored", int'(state_o), 0);

        push(3, 4);
        check("start beats mode", int'(state_o), 1);
        check("running after dual", int'(running), 1);

        ovf_in = 6'b111111;
        wait_tick(found);
        check("pre-reset tick", found, 1);
        step(3);
        int_reset = 1'b1;
        #1;
        check("async reset outputs", int'({digit_adv, clr_hr, sec_tick, state_o, blink_mask, running}), 0);
        step(1);
        check("no strobe in reset", int'({digit_adv, sec_tick}), 0);
        int_reset = 1'b0;
        step(2);
        check("state after reset", int'(state_o), 0);
        strobes = 0;
        step(12);
        check("idle after reset", strobes, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
